// File: rtl/pcs_pma_reset_seq_pkg.sv
// Shared state encodings and per-state output decode for the PCS/PMA reset sequencer.
// Encodings are fixed because the status/CSR block reads the state field.
package pcs_pma_reset_seq_pkg;

    typedef enum logic [2:0] {
        WAIT_LOCK = 3'd0,
        SETTLE    = 3'd1,
        GT_RST    = 3'd2,
        USRRDY    = 3'd3,
        WAIT_DONE = 3'd4,
        READY     = 3'd5,
        RX_RST    = 3'd6,
        FAULT     = 3'd7
    } state_t;

    typedef struct packed {
        logic areset_coreclk;
        logic gttxreset;
        logic gtrxreset;
        logic txuserrdy;
        logic reset_counter_done;
        logic ready;
        logic fault;
    } outs_t;

    localparam outs_t OUTS_RESET = '{
        areset_coreclk     : 1'b1,
        gttxreset          : 1'b1,
        gtrxreset          : 1'b1,
        txuserrdy          : 1'b0,
        reset_counter_done : 1'b0,
        ready              : 1'b0,
        fault              : 1'b0
    };

    // Sideband levels held for the whole time the FSM sits in a state.
    function automatic outs_t state_outs(input state_t s);
        outs_t o;
        o = OUTS_RESET;
        case (s)
            WAIT_LOCK, SETTLE: o = OUTS_RESET;
            GT_RST: begin
                o.areset_coreclk     = 1'b0;
                o.reset_counter_done = 1'b1;
            end
            USRRDY: begin
                o.areset_coreclk     = 1'b0;
                o.reset_counter_done = 1'b1;
                o.gttxreset          = 1'b0;
                o.gtrxreset          = 1'b0;
            end
            WAIT_DONE: begin
                o.areset_coreclk     = 1'b0;
                o.reset_counter_done = 1'b1;
                o.gttxreset          = 1'b0;
                o.gtrxreset          = 1'b0;
                o.txuserrdy          = 1'b1;
            end
            READY: begin
                o.areset_coreclk     = 1'b0;
                o.reset_counter_done = 1'b1;
                o.gttxreset          = 1'b0;
                o.gtrxreset          = 1'b0;
                o.txuserrdy          = 1'b1;
                o.ready              = 1'b1;
            end
            RX_RST: begin
                o.areset_coreclk     = 1'b0;
                o.reset_counter_done = 1'b1;
                o.gttxreset          = 1'b0;
                o.gtrxreset          = 1'b1;
                o.txuserrdy          = 1'b1;
            end
            FAULT: begin
                o       = OUTS_RESET;
                o.fault = 1'b1;
            end
            default: o = OUTS_RESET;
        endcase
        return o;
    endfunction

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/pcs_pma_reset_seq_sync_bit.sv
// Two-flop synchroniser for a single async level; 2-cycle latency, no backpressure.
module sync_bit (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pcs_pma_reset_seq.sv
// Reset sequencer for the 10G PCS/PMA core: QPLL settle, GT reset pulse, user-ready, resetdone wait with retry.
// Outputs registered (one cycle after the deciding input); no backpressure, rx_reset_req outside READY is dropped.
module pcs_pma_reset_seq
    import pcs_pma_reset_seq_pkg::*;
#(
    parameter int RST_CNT_CYCLES = 80,
    parameter int GT_RST_CYCLES  = 16,
    parameter int USRRDY_DLY     = 4,
    parameter int DONE_TIMEOUT   = 65535,
    parameter int MAX_RETRIES    = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       qplllock,
    input  logic       tx_resetdone,
    input  logic       rx_resetdone,
    input  logic       rx_reset_req,
    output logic       areset_coreclk,
    output logic       gttxreset,
    output logic       gtrxreset,
    output logic       txuserrdy,
    output logic       reset_counter_done,
    output logic       ready,
    output logic       fault,
    output logic [2:0] state
);

    // One counter serves every timed state, so it is sized for the longest wait.
    localparam int CNT_MAX = max4(DONE_TIMEOUT, RST_CNT_CYCLES, GT_RST_CYCLES, USRRDY_DLY);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int RTY_W   = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);

    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(RST_CNT_CYCLES - 1);
    localparam logic [CNT_W-1:0] GT_RST_LAST  = CNT_W'(GT_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] USRRDY_LAST  = CNT_W'(USRRDY_DLY - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(DONE_TIMEOUT - 1);
    localparam logic [RTY_W-1:0] RETRY_LIMIT  = RTY_W'(MAX_RETRIES);

    logic lock_s;
    logic tx_s;
    logic rx_s;

    sync_bit u_sync_lock (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (qplllock),
        .q     (lock_s)
    );

    sync_bit u_sync_tx (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (tx_resetdone),
        .q     (tx_s)
    );

    sync_bit u_sync_rx (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rx_resetdone),
        .q     (rx_s)
    );

    state_t           state_q;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_nxt;
    logic [RTY_W-1:0] retry_q;
    logic [RTY_W-1:0] retry_nxt;
    outs_t            outs_q;
    outs_t            outs_nxt;
    logic             lock_lost;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= WAIT_LOCK;
            cnt_q   <= '0;
            retry_q <= '0;
            outs_q  <= OUTS_RESET;
        end else begin
            state_q <= state_nxt;
            cnt_q   <= cnt_nxt;
            retry_q <= retry_nxt;
            outs_q  <= outs_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        retry_nxt = retry_q;
        cnt_nxt   = cnt_q;
        outs_nxt  = OUTS_RESET;
        lock_lost = !lock_s && (state_q != WAIT_LOCK) && (state_q != FAULT);

        case (state_q)
            WAIT_LOCK: begin
                if (lock_s) state_nxt = SETTLE;
            end
            SETTLE: begin
                if (cnt_q == SETTLE_LAST) state_nxt = GT_RST;
            end
            GT_RST: begin
                if (cnt_q == GT_RST_LAST) state_nxt = USRRDY;
            end
            USRRDY: begin
                if (cnt_q == USRRDY_LAST) state_nxt = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (tx_s && rx_s) begin
                    state_nxt = READY;
                    retry_nxt = '0;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    if (retry_q == RETRY_LIMIT) begin
                        state_nxt = FAULT;
                    end else begin
                        state_nxt = GT_RST;
                        retry_nxt = retry_q + 1'b1;
                    end
                end
            end
            READY: begin
                if (rx_reset_req) state_nxt = RX_RST;
            end
            RX_RST: begin
                if (cnt_q == GT_RST_LAST) state_nxt = WAIT_DONE;
            end
            FAULT: begin
                state_nxt = FAULT;
            end
            default: begin
                state_nxt = WAIT_LOCK;
            end
        endcase

        // Lock loss overrides whatever the state decided this cycle.
        if (lock_lost) begin
            state_nxt = WAIT_LOCK;
            retry_nxt = '0;
        end

        if (state_nxt != state_q) begin
            cnt_nxt = '0;
        end else if (cnt_q != {CNT_W{1'b1}}) begin
            cnt_nxt = cnt_q + 1'b1;
        end

        outs_nxt = state_outs(state_nxt);
    end

    assign areset_coreclk     = outs_q.areset_coreclk;
    assign gttxreset          = outs_q.gttxreset;
    assign gtrxreset          = outs_q.gtrxreset;
    assign txuserrdy          = outs_q.txuserrdy;
    assign reset_counter_done = outs_q.reset_counter_done;
    assign ready              = outs_q.ready;
    assign fault              = outs_q.fault;
    assign state              = state_q;

endmodule
